// File: rtl/music_pkg.sv
// Shared definitions for the score sequencer and tone generator: pitch codes, FSM states,
// score entry layout and a default demo score.
package music_pkg;

    localparam int unsigned NOTE_W  = 5;
    localparam int unsigned DUR_W   = 4;
    localparam int unsigned ENTRY_W = NOTE_W + DUR_W;

    // Pitch codes shared with the tone generator; 0 is a rest.
    localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 5'd1;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 5'd3;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 5'd5;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 5'd6;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 5'd8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StPlay,
        StEnd
    } seq_state_e;

    // Entry layout: {note, dur}; dur == 0 marks end of score.
    localparam logic [ENTRY_W-1:0] DEMO_SCORE [64] = '{
        0: {NOTE_C4, 4'd2},
        1: {NOTE_D4, 4'd2},
        2: {NOTE_E4, 4'd2},
        3: {NOTE_F4, 4'd2},
        4: {NOTE_G4, 4'd4},
        5: {NOTE_REST, 4'd2},
        6: {NOTE_G4, 4'd4},
        default: {NOTE_REST, 4'd0}
    };

endpackage

// File: rtl/score_rom.sv
// Synchronous-read score ROM, one-cycle latency; contents come from the INIT table.
module score_rom #(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned DATA_BITS = 9,
    parameter logic [DATA_BITS-1:0] INIT [2**ADDR_BITS] = '{default: '0}
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    always_ff @(posedge clk) begin
        rdata <= INIT[raddr];
    end

endmodule

// File: rtl/music_sequencer.sv
// Score sequencer: walks the score ROM on beat pulses and gates notes to the tone generator.
// Define MUSIC_SEQ_REPEAT_EN to loop the score forever instead of stopping in END.
module music_sequencer
    import music_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned SCORE_LEN = 48,
    parameter int unsigned NOTE_BITS = 5,
    parameter int unsigned DUR_BITS  = 4,
    parameter logic [NOTE_BITS+DUR_BITS-1:0] SCORE_INIT [2**ADDR_BITS] = DEMO_SCORE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 beat,
    input  logic                 play,
    input  logic                 restart,
    output logic [NOTE_BITS-1:0] note,
    output logic                 note_on,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SCORE_LEN - 1);

    seq_state_e                     state_q, state_d;
    logic       [ADDR_BITS-1:0]     addr_q, addr_d;
    logic       [NOTE_BITS-1:0]     note_q, note_d;
    logic       [DUR_BITS-1:0]      cnt_q, cnt_d;
    logic [NOTE_BITS+DUR_BITS-1:0]  entry;
    logic       [NOTE_BITS-1:0]     entry_note;
    logic       [DUR_BITS-1:0]      entry_dur;

    score_rom #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_BITS(NOTE_BITS + DUR_BITS),
        .INIT     (SCORE_INIT)
    ) u_rom (
        .clk  (clk),
        .raddr(addr_q),
        .rdata(entry)
    );

    assign entry_note = entry[NOTE_BITS+DUR_BITS-1:DUR_BITS];
    assign entry_dur  = entry[DUR_BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            note_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            note_q  <= note_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        note_d  = note_q;
        cnt_d   = cnt_q;
        if (restart) begin
            addr_d  = '0;
            state_d = StFetch;
        end else begin
            unique case (state_q)
                StIdle:  if (play) state_d = StFetch;
                StFetch: state_d = StLoad;
                StLoad: begin
                    if (entry_dur == '0) begin
`ifdef MUSIC_SEQ_REPEAT_EN
                        addr_d  = '0;
                        state_d = StFetch;
`else
                        note_d  = '0;
                        state_d = StEnd;
`endif
                    end else begin
                        note_d  = entry_note;
                        cnt_d   = entry_dur;
                        state_d = StPlay;
                    end
                end
                StPlay: begin
                    // Beats while paused are dropped so the remaining duration is frozen.
                    if (beat && play) begin
                        if (cnt_q == DUR_BITS'(1)) begin
                            if (addr_q == LAST_ADDR) begin
`ifdef MUSIC_SEQ_REPEAT_EN
                                addr_d  = '0;
                                state_d = StFetch;
`else
                                note_d  = '0;
                                state_d = StEnd;
`endif
                            end else begin
                                addr_d  = addr_q + ADDR_BITS'(1);
                                state_d = StFetch;
                            end
                        end else begin
                            cnt_d = cnt_q - DUR_BITS'(1);
                        end
                    end
                end
                StEnd:   state_d = StEnd;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        note    = note_q;
        addr    = addr_q;
        note_on = (state_q == StPlay) && play && (note_q != '0);
        busy    = (state_q == StFetch) || (state_q == StLoad) || (state_q == StPlay);
        done    = (state_q == StEnd);
    end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: one instance on a short ending score, one with
// SCORE_LEN=4 and all-nonzero durations for pause, wrap/end and beat-in-LOAD scenarios.
module tb_music_sequencer;

`ifdef MUSIC_SEQ_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    localparam logic [8:0] SCORE_A [64] = '{
        0: {5'd5, 4'd2}, 1: {5'd7, 4'd1}, 2: {5'd0, 4'd1}, 3: {5'd3, 4'd0},
        default: 9'h000
    };
    localparam logic [8:0] SCORE_B [64] = '{
        0: {5'd5, 4'd3}, 1: {5'd6, 4'd1}, 2: {5'd7, 4'd2}, 3: {5'd9, 4'd1},
        default: 9'h000
    };

    logic       clk = 1'b0;
    logic       rst, beat, play, restart;
    logic [4:0] a_note, b_note;
    logic       a_on, b_on, a_busy, b_busy, a_done, b_done;
    logic [5:0] a_addr, b_addr;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    music_sequencer #(
        .ADDR_BITS(6), .SCORE_LEN(48), .NOTE_BITS(5), .DUR_BITS(4), .SCORE_INIT(SCORE_A)
    ) dut_a (
        .clk(clk), .rst(rst), .beat(beat), .play(play), .restart(restart),
        .note(a_note), .note_on(a_on), .addr(a_addr), .busy(a_busy), .done(a_done)
    );

    music_sequencer #(
        .ADDR_BITS(6), .SCORE_LEN(4), .NOTE_BITS(5), .DUR_BITS(4), .SCORE_INIT(SCORE_B)
    ) dut_b (
        .clk(clk), .rst(rst), .beat(beat), .play(play), .restart(restart),
        .note(b_note), .note_on(b_on), .addr(b_addr), .busy(b_busy), .done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat();
        beat = 1'b1;
        tick();
        beat = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; play = 1'b0; beat = 1'b0; restart = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        play = 1'b1;
        repeat (3) tick();
        n_vec++; if (a_on !== 1'b1) begin n_err++; $display("FAIL rst_pre_play: note_on=%0b want 1", a_on); end
        send_beat();
        #3 rst = 1'b1;
        #1;
        n_vec++; if ({a_on, a_note, a_addr, a_busy, a_done} !== 14'd0) begin
            n_err++; $display("FAIL rst_async: on=%0b note=%0d addr=%0d busy=%0b done=%0b want all 0",
                              a_on, a_note, a_addr, a_busy, a_done);
        end
        play = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        n_vec++; if ({a_busy, a_on, a_addr} !== 8'd0) begin
            n_err++; $display("FAIL rst_idle_hold: busy=%0b on=%0b addr=%0d want 0 0 0", a_busy, a_on, a_addr);
        end
    endtask

    task automatic test_score();
        do_reset();
        play = 1'b1;
        tick();
        n_vec++; if (a_busy !== 1'b1 || a_on !== 1'b0) begin
            n_err++; $display("FAIL score_fetch: busy=%0b on=%0b want 1 0", a_busy, a_on);
        end
        tick();
        n_vec++; if (a_on !== 1'b0) begin n_err++; $display("FAIL score_load: on=%0b want 0", a_on); end
        tick();
        n_vec++; if (a_on !== 1'b1 || a_note !== 5'd5) begin
            n_err++; $display("FAIL score_first: on=%0b note=%0d want 1 5", a_on, a_note);
        end
        send_beat();
        repeat (9) tick();
        n_vec++; if (a_on !== 1'b1 || a_note !== 5'd5 || a_addr !== 6'd0) begin
            n_err++; $display("FAIL score_n0_beat1: on=%0b note=%0d addr=%0d want 1 5 0", a_on, a_note, a_addr);
        end
        send_beat();
        n_vec++; if (a_on !== 1'b0 || a_note !== 5'd5 || a_addr !== 6'd1) begin
            n_err++; $display("FAIL score_gap: on=%0b note=%0d addr=%0d want 0 5 1", a_on, a_note, a_addr);
        end
        tick(); tick();
        n_vec++; if (a_on !== 1'b1 || a_note !== 5'd7) begin
            n_err++; $display("FAIL score_n1: on=%0b note=%0d want 1 7", a_on, a_note);
        end
        repeat (7) tick();
        send_beat();
        tick(); tick();
        n_vec++; if (a_on !== 1'b0 || a_note !== 5'd0 || a_addr !== 6'd2 || a_busy !== 1'b1) begin
            n_err++; $display("FAIL score_rest: on=%0b note=%0d addr=%0d busy=%0b want 0 0 2 1",
                              a_on, a_note, a_addr, a_busy);
        end
        repeat (7) tick();
        send_beat();
        tick(); tick();
        n_vec++; if (a_done !== !REP || a_busy !== REP || a_note !== 5'd0 || a_on !== 1'b0) begin
            n_err++; $display("FAIL score_end: done=%0b busy=%0b note=%0d on=%0b want %0b %0b 0 0",
                              a_done, a_busy, a_note, a_on, !REP, REP);
        end
        n_vec++; if (a_addr !== (REP ? 6'd0 : 6'd3)) begin
            n_err++; $display("FAIL score_end_addr: addr=%0d want %0d", a_addr, REP ? 0 : 3);
        end
    endtask

    task automatic test_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_vec++; if (a_done !== 1'b0 || a_addr !== 6'd0 || a_busy !== 1'b1) begin
            n_err++; $display("FAIL rs_end: done=%0b addr=%0d busy=%0b want 0 0 1", a_done, a_addr, a_busy);
        end
        tick(); tick();
        n_vec++; if (a_on !== 1'b1 || a_note !== 5'd5) begin
            n_err++; $display("FAIL rs_first: on=%0b note=%0d want 1 5", a_on, a_note);
        end
        send_beat(); repeat (4) tick();
        send_beat(); repeat (4) tick();
        send_beat(); repeat (4) tick();
        n_vec++; if (a_addr !== 6'd2 || a_busy !== 1'b1) begin
            n_err++; $display("FAIL rs_at2: addr=%0d busy=%0b want 2 1", a_addr, a_busy);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_vec++; if (a_addr !== 6'd0 || a_on !== 1'b0) begin
            n_err++; $display("FAIL rs_mid: addr=%0d on=%0b want 0 0", a_addr, a_on);
        end
        tick(); tick();
        n_vec++; if (a_on !== 1'b1 || a_note !== 5'd5) begin
            n_err++; $display("FAIL rs_mid_first: on=%0b note=%0d want 1 5", a_on, a_note);
        end
    endtask

    task automatic test_pause_and_wrap();
        do_reset();
        play = 1'b1;
        repeat (3) tick();
        send_beat();
        repeat (4) tick();
        play = 1'b0;
        tick();
        n_vec++; if (b_on !== 1'b0 || b_note !== 5'd5) begin
            n_err++; $display("FAIL pause_gate: on=%0b note=%0d want 0 5", b_on, b_note);
        end
        for (int i = 0; i < 4; i++) begin
            send_beat();
            repeat (4) tick();
        end
        n_vec++; if (b_addr !== 6'd0 || b_on !== 1'b0 || b_busy !== 1'b1) begin
            n_err++; $display("FAIL pause_frozen: addr=%0d on=%0b busy=%0b want 0 0 1", b_addr, b_on, b_busy);
        end
        play = 1'b1;
        tick();
        n_vec++; if (b_on !== 1'b1) begin n_err++; $display("FAIL pause_resume: on=%0b want 1", b_on); end
        send_beat();
        repeat (4) tick();
        n_vec++; if (b_addr !== 6'd0 || b_note !== 5'd5) begin
            n_err++; $display("FAIL pause_beat2: addr=%0d note=%0d want 0 5", b_addr, b_note);
        end
        send_beat();
        n_vec++; if (b_addr !== 6'd1) begin n_err++; $display("FAIL pause_beat3: addr=%0d want 1", b_addr); end
        tick(); tick();
        n_vec++; if (b_note !== 5'd6 || b_on !== 1'b1) begin
            n_err++; $display("FAIL wrap_n1: note=%0d on=%0b want 6 1", b_note, b_on);
        end
        send_beat(); repeat (4) tick();
        send_beat(); repeat (4) tick();
        send_beat(); repeat (4) tick();
        n_vec++; if (b_note !== 5'd9 || b_addr !== 6'd3) begin
            n_err++; $display("FAIL wrap_n3: note=%0d addr=%0d want 9 3", b_note, b_addr);
        end
        send_beat();
        n_vec++; if (b_done !== !REP || b_busy !== REP || b_addr !== (REP ? 6'd0 : 6'd3)) begin
            n_err++; $display("FAIL wrap_last: done=%0b busy=%0b addr=%0d want %0b %0b %0d",
                              b_done, b_busy, b_addr, !REP, REP, REP ? 0 : 3);
        end
        tick(); tick();
        n_vec++; if (b_on !== REP || b_note !== (REP ? 5'd5 : 5'd0)) begin
            n_err++; $display("FAIL wrap_after: on=%0b note=%0d want %0b %0d", b_on, b_note, REP, REP ? 5 : 0);
        end
    endtask

    task automatic test_beat_in_load();
        do_reset();
        play = 1'b1;
        tick();
        tick();
        send_beat();
        n_vec++; if (b_note !== 5'd5 || b_on !== 1'b1) begin
            n_err++; $display("FAIL load_beat_play: note=%0d on=%0b want 5 1", b_note, b_on);
        end
        for (int i = 0; i < 2; i++) begin
            repeat (4) tick();
            send_beat();
        end
        n_vec++; if (b_addr !== 6'd0 || b_on !== 1'b1) begin
            n_err++; $display("FAIL load_beat_full: addr=%0d on=%0b want 0 1", b_addr, b_on);
        end
        repeat (4) tick();
        send_beat();
        n_vec++; if (b_addr !== 6'd1) begin n_err++; $display("FAIL load_beat_adv: addr=%0d want 1", b_addr); end
    endtask

    initial begin
        test_reset();
        test_score();
        test_restart();
        test_pause_and_wrap();
        test_beat_in_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
